sha3_arbiter: RTL

SHA3_ARBITER -- requirements
Module: sha3_arbiter

---
 rtl/sha3_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha3_arbiter.sv
// sha3_arbiter: shares one SHA3 core between two requesters (grant, absorb, digest drain).
// Define SHA3_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for requester 0.
module sha3_arbiter #(
  parameter int DIGEST_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_start,
  input  logic [127:0] req_data,
  input  logic [1:0]   req_last,
  input  logic [1:0]   req_wvalid,
  output logic [1:0]   req_wready,
  output logic [1:0]   gnt,
  output logic [63:0]  rsp_data,
  output logic [1:0]   rsp_vld,
  output logic [1:0]   rsp_done,
  output logic         core_start,
  output logic [63:0]  core_data,
  output logic         core_last,
  output logic         core_wvalid,
  input  logic         core_wready,
  input  logic [63:0]  core_dout,
  input  logic         core_dout_vld,
  output logic         busy
);

  // state  | meaning
  // IDLE   | no owner; arbitrate req_start
  // START  | owner granted; launches the one-cycle core_start pulse
  // ABSORB | owner's message words forwarded to the core
  // DRAIN  | digest words returned to the owner
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ABSORB = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam int CW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGEST_WORDS - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          owner_q, owner_d;
  logic          core_start_q, core_start_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifndef SHA3_ARB_FIXED_PRIO_EN
  logic          ptr_q, ptr_d;
`endif

  logic          sel;
  logic          in_absorb;
  logic          drain_vld;
  logic          dig_last;
  logic          xfer;
  logic [63:0]   own_data;

`ifdef SHA3_ARB_FIXED_PRIO_EN
  assign sel = ~req_start[0];
`else
  // On a tie the pointer names the requester that was not served last.
  assign sel = (req_start == 2'b11) ? ptr_q : req_start[1];
`endif

  assign in_absorb = (state_q == ABSORB);
  assign own_data  = owner_q ? req_data[127:64] : req_data[63:0];

  assign core_data   = in_absorb ? own_data : 64'd0;
  assign core_last   = in_absorb & req_last[owner_q];
  assign core_wvalid = in_absorb & req_wvalid[owner_q];
  assign xfer        = core_wvalid & core_wready;

  assign drain_vld = (state_q == DRAIN) & core_dout_vld;
  assign dig_last  = drain_vld & (cnt_q == CNT_LAST);
  assign rsp_data  = drain_vld ? core_dout : 64'd0;

  always_comb begin
    req_wready = 2'b00;
    rsp_vld    = 2'b00;
    rsp_done   = 2'b00;
    if (in_absorb) req_wready[owner_q] = core_wready;
    if (drain_vld) rsp_vld[owner_q] = 1'b1;
    if (dig_last)  rsp_done[owner_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_start) begin
          owner_d = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        core_start_d = 1'b1;
        state_d      = ABSORB;
      end
      ABSORB: begin
        if (xfer && core_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dig_last) begin
          gnt_d   = 2'b00;
          cnt_d   = '0;
          state_d = IDLE;
`ifndef SHA3_ARB_FIXED_PRIO_EN
          ptr_d   = ~owner_q;
`endif
        end else if (drain_vld) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
`ifndef SHA3_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;

endmodule
